// File: rtl/atb_pkg.sv
// Shared definitions for the ATB protocol checker: rule bit positions,
// the reserved trace-ID test and the flush tracker state encoding.
package atb_pkg;

    localparam int RULE_ILLEGAL_ID     = 0;
    localparam int RULE_VALID_DROP     = 1;
    localparam int RULE_PAYLOAD_CHANGE = 2;
    localparam int RULE_BYTES_RANGE    = 3;
    localparam int RULE_FLUSH_DROP     = 4;
    localparam int RULE_AFREADY_NO_REQ = 5;
    localparam int RULE_FLUSH_TMO      = 6;
    localparam int RULE_NO_WAKEUP      = 7;
    localparam int NUM_RULES           = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } flush_state_e;

    // IDs 0x00, 0x70-0x7C, 0x7E and 0x7F are reserved by the ATB protocol
    function automatic logic atb_id_reserved(input logic [6:0] id);
        return (id == 7'h00) || ((id >= 7'h70) && (id <= 7'h7C)) || (id >= 7'h7E);
    endfunction

endpackage

// File: rtl/atb_flush_tracker.sv
// Flush handshake tracker: follows afvalid/afready and raises a one-shot
// timeout when a flush request waits FLUSH_TMO enabled cycles unanswered.
module atb_flush_tracker
    import atb_pkg::*;
#(
    parameter int FLUSH_TMO = 256
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clken,
    input  logic i_afvalid,
    input  logic i_afready,
    output logic o_tmoPulse,
    output logic o_busy
);

    localparam int TW = $clog2(FLUSH_TMO + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(FLUSH_TMO);

    flush_state_e  r_state;
    flush_state_e  w_nextState;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_nextTimer;
    logic          w_tmo;

    // The timer saturates at TMO_MAX so the timeout fires exactly once per wait
    always_comb begin
        w_nextState = r_state;
        w_nextTimer = r_timer;
        w_tmo       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_afvalid && i_afready) begin
                    w_nextState = DONE;
                end else if (i_afvalid) begin
                    w_nextState = WAIT;
                    w_nextTimer = TW'(1);
                    w_tmo       = (TMO_MAX == TW'(1));
                end
            end
            WAIT: begin
                if (!i_afvalid) begin
                    w_nextState = IDLE;
                    w_nextTimer = '0;
                end else if (i_afready) begin
                    w_nextState = DONE;
                    w_nextTimer = '0;
                end else if (r_timer != TMO_MAX) begin
                    w_nextTimer = r_timer + TW'(1);
                    w_tmo       = ((r_timer + TW'(1)) == TMO_MAX);
                end
            end
            DONE: begin
                w_nextState = IDLE;
                w_nextTimer = '0;
            end
            default: begin
                w_nextState = IDLE;
                w_nextTimer = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else if (i_clken) begin
            r_state <= w_nextState;
            r_timer <= w_nextTimer;
        end
    end

    assign o_tmoPulse = w_tmo;
    assign o_busy     = (r_state != IDLE);

endmodule

// File: rtl/atb_protocol_checker.sv
// Passive ATB link checker: evaluates eight protocol rules per enabled cycle
// and reports registered pulses, sticky flags, an error counter and a beat counter.
module atb_protocol_checker
    import atb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTES_W    = ((DATA_WIDTH / 8) > 1) ? $clog2(DATA_WIDTH / 8) : 1,
    parameter int ID_WIDTH   = 7,
    parameter int FLUSH_TMO  = 256,
    parameter int CNT_W      = 16
) (
    input  logic                  atclk,
    input  logic                  atreset,
    input  logic                  atclken,
    input  logic [DATA_WIDTH-1:0] atdata,
    input  logic [BYTES_W-1:0]    atbytes,
    input  logic [ID_WIDTH-1:0]   atid,
    input  logic                  atvalid,
    input  logic                  atready,
    input  logic                  afvalid,
    input  logic                  afready,
    input  logic                  atwakeup,
    input  logic                  clr,
    output logic [NUM_RULES-1:0]  err_pulse,
    output logic [NUM_RULES-1:0]  err_sticky,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [CNT_W-1:0]      beat_cnt,
    output logic                  flush_busy
);

    localparam int MAX_BYTES = (DATA_WIDTH / 8) - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                  r_prevStall;
    logic                  r_prevAfStall;
    logic [DATA_WIDTH-1:0] r_prevData;
    logic [BYTES_W-1:0]    r_prevBytes;
    logic [ID_WIDTH-1:0]   r_prevId;
    logic [NUM_RULES-1:0]  r_errPulse;
    logic [NUM_RULES-1:0]  r_errSticky;
    logic [CNT_W-1:0]      r_errCnt;
    logic [CNT_W-1:0]      r_beatCnt;

    logic [NUM_RULES-1:0]  w_rules;
    logic                  w_beat;
    logic                  w_idReserved;
    logic                  w_tmoPulse;
    logic                  w_busy;

    assign w_beat = atvalid && atready;

    // The reserved-ID table is only meaningful for the architectural 7-bit ID
    if (ID_WIDTH == 7) begin : g_idCheck
        assign w_idReserved = atb_id_reserved(atid);
    end else begin : g_noIdCheck
        assign w_idReserved = 1'b0;
    end

    atb_flush_tracker #(
        .FLUSH_TMO (FLUSH_TMO)
    ) u_flush (
        .i_clk      (atclk),
        .i_rst      (atreset),
        .i_clken    (atclken),
        .i_afvalid  (afvalid),
        .i_afready  (afready),
        .o_tmoPulse (w_tmoPulse),
        .o_busy     (w_busy)
    );

    always_comb begin
        w_rules                      = '0;
        w_rules[RULE_ILLEGAL_ID]     = w_beat && w_idReserved;
        w_rules[RULE_VALID_DROP]     = r_prevStall && !atvalid;
        w_rules[RULE_PAYLOAD_CHANGE] = r_prevStall && ((atdata != r_prevData) ||
                                       (atbytes != r_prevBytes) || (atid != r_prevId));
        w_rules[RULE_BYTES_RANGE]    = atvalid && (32'(atbytes) > MAX_BYTES);
        w_rules[RULE_FLUSH_DROP]     = r_prevAfStall && !afvalid;
        w_rules[RULE_AFREADY_NO_REQ] = afready && !afvalid;
        w_rules[RULE_FLUSH_TMO]      = w_tmoPulse;
        w_rules[RULE_NO_WAKEUP]      = atvalid && !atwakeup;
    end

    // A disabled cycle clears the pulse but leaves the previous-sample history intact
    always_ff @(posedge atclk or posedge atreset) begin
        if (atreset) begin
            r_errPulse    <= '0;
            r_prevStall   <= 1'b0;
            r_prevAfStall <= 1'b0;
            r_prevData    <= '0;
            r_prevBytes   <= '0;
            r_prevId      <= '0;
        end else if (atclken) begin
            r_errPulse    <= w_rules;
            r_prevStall   <= atvalid && !atready;
            r_prevAfStall <= afvalid && !afready;
            r_prevData    <= atdata;
            r_prevBytes   <= atbytes;
            r_prevId      <= atid;
        end else begin
            r_errPulse    <= '0;
        end
    end

    always_ff @(posedge atclk or posedge atreset) begin
        if (atreset) begin
            r_errSticky <= '0;
            r_errCnt    <= '0;
            r_beatCnt   <= '0;
        end else if (atclken) begin
            if (clr) begin
                r_errSticky <= '0;
                r_errCnt    <= '0;
                r_beatCnt   <= '0;
            end else begin
                r_errSticky <= r_errSticky | w_rules;
                if ((|w_rules) && (r_errCnt != CNT_MAX)) begin
                    r_errCnt <= r_errCnt + CNT_W'(1);
                end
                if (w_beat) begin
                    r_beatCnt <= r_beatCnt + CNT_W'(1);
                end
            end
        end
    end

    assign err_pulse  = r_errPulse;
    assign err_sticky = r_errSticky;
    assign err_cnt    = r_errCnt;
    assign beat_cnt   = r_beatCnt;
    assign flush_busy = w_busy;

endmodule

// File: tb/tb_atb_protocol_checker.sv
// Scoreboard bench for atb_protocol_checker: directed cycles push expected
// outputs into a queue that a monitor pops one cycle later and compares.
module tb_atb_protocol_checker;

    localparam int DATA_WIDTH = 32;
    localparam int BYTES_W    = 2;
    localparam int ID_WIDTH   = 7;
    localparam int FLUSH_TMO  = 4;
    localparam int CNT_W      = 4;

    logic                  atclk = 1'b0;
    logic                  atreset = 1'b1;
    logic                  atclken = 1'b1;
    logic [DATA_WIDTH-1:0] atdata = '0;
    logic [BYTES_W-1:0]    atbytes = 2'd3;
    logic [ID_WIDTH-1:0]   atid = 7'h10;
    logic                  atvalid = 1'b0;
    logic                  atready = 1'b0;
    logic                  afvalid = 1'b0;
    logic                  afready = 1'b0;
    logic                  atwakeup = 1'b1;
    logic                  clr = 1'b0;
    logic [7:0]            err_pulse;
    logic [7:0]            err_sticky;
    logic [CNT_W-1:0]      err_cnt;
    logic [CNT_W-1:0]      beat_cnt;
    logic                  flush_busy;

    typedef struct {
        int         due;
        string      name;
        logic [4:0] mask;
        logic [7:0] pulse;
        logic [7:0] sticky;
        logic [3:0] errCnt;
        logic [3:0] beatCnt;
        logic       busy;
    } ScoreEntry;

    ScoreEntry scoreQ[$];
    int cycleCount = 0;
    int testsRun = 0;
    int failCount = 0;

    localparam logic [4:0] M_PULSE = 5'b00001;
    localparam logic [4:0] M_STICK = 5'b00010;
    localparam logic [4:0] M_ERR   = 5'b00100;
    localparam logic [4:0] M_BEAT  = 5'b01000;
    localparam logic [4:0] M_BUSY  = 5'b10000;
    localparam logic [4:0] M_ALL   = 5'b11111;

    atb_protocol_checker #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTES_W    (BYTES_W),
        .ID_WIDTH   (ID_WIDTH),
        .FLUSH_TMO  (FLUSH_TMO),
        .CNT_W      (CNT_W)
    ) dut (
        .atclk      (atclk),
        .atreset    (atreset),
        .atclken    (atclken),
        .atdata     (atdata),
        .atbytes    (atbytes),
        .atid       (atid),
        .atvalid    (atvalid),
        .atready    (atready),
        .afvalid    (afvalid),
        .afready    (afready),
        .atwakeup   (atwakeup),
        .clr        (clr),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt),
        .beat_cnt   (beat_cnt),
        .flush_busy (flush_busy)
    );

    always #5 atclk = ~atclk;

    always @(posedge atclk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string nm, input logic [15:0] act, input logic [15:0] req);
        testsRun++;
        if (act !== req) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Inputs are already driven at this negedge; the expectation is due after the next posedge
    task automatic applyStimulus(input string nm, input logic [4:0] mask, input logic [7:0] ePulse,
                                 input logic [7:0] eSticky, input logic [3:0] eErr,
                                 input logic [3:0] eBeat, input logic eBusy);
        ScoreEntry e;
        e.due     = cycleCount + 1;
        e.name    = nm;
        e.mask    = mask;
        e.pulse   = ePulse;
        e.sticky  = eSticky;
        e.errCnt  = eErr;
        e.beatCnt = eBeat;
        e.busy    = eBusy;
        scoreQ.push_back(e);
        @(negedge atclk);
    endtask

    task automatic setIdle();
        atvalid  = 1'b0;
        atready  = 1'b0;
        afvalid  = 1'b0;
        afready  = 1'b0;
        atwakeup = 1'b1;
        atclken  = 1'b1;
        clr      = 1'b0;
        atid     = 7'h10;
        atbytes  = 2'd3;
    endtask

    initial begin : monitor
        ScoreEntry e;
        forever begin
            @(posedge atclk);
            #2;
            while (scoreQ.size() > 0 && scoreQ[0].due <= cycleCount) begin
                e = scoreQ.pop_front();
                checkOutput({e.name, ".due"}, 16'(e.due), 16'(cycleCount));
                if (e.mask[0]) checkOutput({e.name, ".pulse"}, 16'(err_pulse), 16'(e.pulse));
                if (e.mask[1]) checkOutput({e.name, ".sticky"}, 16'(err_sticky), 16'(e.sticky));
                if (e.mask[2]) checkOutput({e.name, ".errCnt"}, 16'(err_cnt), 16'(e.errCnt));
                if (e.mask[3]) checkOutput({e.name, ".beatCnt"}, 16'(beat_cnt), 16'(e.beatCnt));
                if (e.mask[4]) checkOutput({e.name, ".busy"}, 16'(flush_busy), 16'(e.busy));
            end
        end
    end

    initial begin : stimulus
        setIdle();
        repeat (2) @(negedge atclk);
        applyStimulus("reset", M_ALL, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0);
        atreset = 1'b0;
        applyStimulus("idle0", M_ALL, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0);

        // Reserved ID check: 0x7D is legal, 0x70 is reserved
        atvalid = 1'b1; atready = 1'b1; atid = 7'h7D;
        applyStimulus("id7D", M_ALL, 8'h00, 8'h00, 4'd0, 4'd1, 1'b0);
        atid = 7'h70;
        applyStimulus("id70", M_ALL, 8'h01, 8'h01, 4'd1, 4'd2, 1'b0);
        setIdle(); atid = 7'h70;
        applyStimulus("idAfter", M_ALL, 8'h00, 8'h01, 4'd1, 4'd2, 1'b0);
        setIdle(); clr = 1'b1;
        applyStimulus("clr1", M_ALL, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0);

        // Stall with the payload changing on its second cycle
        setIdle(); atvalid = 1'b1; atdata = 32'hAAAA_0001;
        applyStimulus("stall1", M_ALL, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0);
        atdata = 32'hBBBB_0002;
        applyStimulus("stall2", M_ALL, 8'h04, 8'h04, 4'd1, 4'd0, 1'b0);
        applyStimulus("stall3", M_ALL, 8'h00, 8'h04, 4'd1, 4'd0, 1'b0);
        atready = 1'b1;
        applyStimulus("stallAccept", M_ALL, 8'h00, 8'h04, 4'd1, 4'd1, 1'b0);
        setIdle();
        applyStimulus("idle1", M_PULSE | M_ERR, 8'h00, 8'h04, 4'd1, 4'd1, 1'b0);

        // Valid drops while atclken is low; the drop is judged at the next enabled sample
        atvalid = 1'b1; atdata = 32'hCCCC_0003;
        applyStimulus("ceStall", M_ALL, 8'h00, 8'h04, 4'd1, 4'd1, 1'b0);
        atclken = 1'b0; atvalid = 1'b0;
        applyStimulus("ceOff", M_ALL, 8'h00, 8'h04, 4'd1, 4'd1, 1'b0);
        atclken = 1'b1;
        applyStimulus("ceDrop", M_ALL, 8'h02, 8'h06, 4'd2, 4'd1, 1'b0);
        setIdle();
        applyStimulus("idle2", M_PULSE | M_ERR, 8'h00, 8'h06, 4'd2, 4'd1, 1'b0);

        // Rules 5 and 7 together count as one error cycle
        atvalid = 1'b1; atready = 1'b1; atwakeup = 1'b0; afready = 1'b1;
        applyStimulus("r5r7", M_ALL, 8'hA0, 8'hA6, 4'd3, 4'd2, 1'b0);
        setIdle();
        applyStimulus("idle3", M_PULSE | M_ERR, 8'h00, 8'hA6, 4'd3, 4'd2, 1'b0);
        afready = 1'b1; clr = 1'b1;
        applyStimulus("clrWithErr", M_ALL, 8'h20, 8'h00, 4'd0, 4'd0, 1'b0);
        setIdle();
        applyStimulus("idle4", M_ALL, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0);

        // Flush request held unanswered: timeout on the fourth enabled cycle only
        afvalid = 1'b1;
        applyStimulus("tmo1", M_ALL, 8'h00, 8'h00, 4'd0, 4'd0, 1'b1);
        applyStimulus("tmo2", M_ALL, 8'h00, 8'h00, 4'd0, 4'd0, 1'b1);
        applyStimulus("tmo3", M_ALL, 8'h00, 8'h00, 4'd0, 4'd0, 1'b1);
        applyStimulus("tmo4", M_ALL, 8'h40, 8'h40, 4'd1, 4'd0, 1'b1);
        applyStimulus("tmo5", M_ALL, 8'h00, 8'h40, 4'd1, 4'd0, 1'b1);
        applyStimulus("tmo6", M_ALL, 8'h00, 8'h40, 4'd1, 4'd0, 1'b1);
        afready = 1'b1;
        applyStimulus("flushAck", M_ALL, 8'h00, 8'h40, 4'd1, 4'd0, 1'b1);
        setIdle();
        applyStimulus("flushDone", M_ALL, 8'h00, 8'h40, 4'd1, 4'd0, 1'b0);

        afvalid = 1'b1;
        applyStimulus("afStall", M_ALL, 8'h00, 8'h40, 4'd1, 4'd0, 1'b1);
        afvalid = 1'b0;
        applyStimulus("afDrop", M_ALL, 8'h10, 8'h50, 4'd2, 4'd0, 1'b0);

        // 16 beats on a 4-bit counter wrap back to zero
        for (int k = 0; k < 16; k++) begin
            atvalid = 1'b1; atready = 1'b1;
            applyStimulus($sformatf("wrap%0d", k), M_BEAT, 8'h00, 8'h00, 4'd0, 4'((k + 1) % 16), 1'b0);
        end
        setIdle();
        applyStimulus("idle5", M_PULSE | M_ERR | M_BEAT, 8'h00, 8'h00, 4'd2, 4'd0, 1'b0);

        // 20 error cycles saturate the 4-bit error counter at 15
        for (int k = 0; k < 20; k++) begin
            afready = 1'b1;
            applyStimulus($sformatf("sat%0d", k), M_PULSE | M_ERR, 8'h20, 8'h00,
                          4'(((k + 3) > 15) ? 15 : (k + 3)), 4'd0, 1'b0);
        end
        setIdle();
        applyStimulus("idle6", M_PULSE | M_ERR, 8'h00, 8'h00, 4'd15, 4'd0, 1'b0);

        // Reset in the middle of a flush wait: no timeout afterwards
        afvalid = 1'b1;
        applyStimulus("rstWait1", M_BUSY, 8'h00, 8'h00, 4'd0, 4'd0, 1'b1);
        applyStimulus("rstWait2", M_BUSY | M_PULSE, 8'h00, 8'h00, 4'd0, 4'd0, 1'b1);
        atreset = 1'b1; afvalid = 1'b0;
        applyStimulus("rstMid", M_ALL, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0);
        atreset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus($sformatf("postRst%0d", k), M_ALL, 8'h00, 8'h00, 4'd0, 4'd0, 1'b0);
        end

        repeat (3) @(negedge atclk);
        checkOutput("drain", 16'(scoreQ.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
